jacobi_input_adapter: RTL and testbench

- AXI4-Stream slave front end that feeds the Jacobi top-level input port (in_dat_i/in_vld_i/in_rdy_o) from the DMA/AXI FIFO.
- Extracts one matrix element per AXI beat, counts elements of each N×N matrix and enforces framing against tlast.
- Recovers from malformed frames: pads short frames with zeros and drops the surplus of long ones.
- Registered tready/tvalid through a 2-entry skid buffer, so no combinational path crosses the block.

---
 rtl/jacobi_input_adapter_pkg.sv | 10 +
 rtl/axis_skid_buffer.sv | 46 ++++
 rtl/jacobi_input_adapter.sv | 77 +++++++
 tb/tb_jacobi_input_adapter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jacobi_input_adapter_pkg.sv
// jacobi_input_adapter_pkg: shared sizes and adapter state encoding for the Jacobi input path
package jacobi_input_adapter_pkg;
  localparam int JACOBI_MATRIX_SIZE = 8;
  localparam int JACOBI_INPUT_WORD_WIDTH = 16;
  localparam int AXI4_FIFO_WORD_WIDTH = 32;
  typedef enum logic [1:0] {RUN, PAD, DROP} adapter_state_e;
  function automatic int cnt_width(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry register slice with registered ready and valid
module axis_skid_buffer #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] s_data_i,
  input  logic         s_vld_i,
  output logic         s_rdy_o,
  output logic [W-1:0] m_data_o,
  output logic         m_vld_o,
  input  logic         m_rdy_i
);
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q, rdy_d;
  logic push, pop, load;
  // skid only fills when main is occupied and not draining
  always_comb begin
    push = s_vld_i & rdy_q;
    pop = main_vld_q & m_rdy_i;
    load = !main_vld_q | pop;
    main_vld_d = load ? (skid_vld_q | push) : main_vld_q;
    main_d = (load & skid_vld_q) ? skid_q : (load & push) ? s_data_i : main_q;
    skid_vld_d = skid_vld_q ? !pop : (push & !load);
    skid_d = (!skid_vld_q & push & !load) ? s_data_i : skid_q;
    rdy_d = !skid_vld_d;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_q <= '0;
      skid_q <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q <= rdy_d;
    end
  end
  assign s_rdy_o = rdy_q;
  assign m_data_o = main_q;
  assign m_vld_o = main_vld_q;
endmodule

// File: rtl/jacobi_input_adapter.sv
// jacobi_input_adapter: AXI4-Stream slave that frames N*N matrix elements for the Jacobi core
module jacobi_input_adapter
  import jacobi_input_adapter_pkg::*;
#(
  parameter int AXI_W = AXI4_FIFO_WORD_WIDTH,
  parameter int IN_W  = JACOBI_INPUT_WORD_WIDTH,
  parameter int N     = JACOBI_MATRIX_SIZE
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [AXI_W-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [IN_W-1:0]  m_dat_o,
  output logic             m_vld_o,
  input  logic             m_rdy_i,
  output logic             frame_done_o,
  output logic             err_short_o,
  output logic             err_long_o
);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N * N - 1);
  adapter_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_short_q, err_short_d, err_long_q, err_long_d;
  logic buf_rdy, in_fire, at_last, push, out_tag;
  logic [IN_W-1:0] push_dat;
  logic unused_tdata;
  assign unused_tdata = ^s_axis_tdata;
  assign s_axis_tready = (state_q == DROP) | ((state_q == RUN) & buf_rdy);
  assign in_fire = s_axis_tvalid & s_axis_tready;
  assign at_last = cnt_q == LAST;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      cnt_q <= '0;
      err_short_q <= 1'b0;
      err_long_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_short_q <= err_short_d;
      err_long_q <= err_long_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:  state_d = !in_fire ? RUN : (s_axis_tlast & !at_last) ? PAD : (!s_axis_tlast & at_last) ? DROP : RUN;
      PAD:  state_d = (buf_rdy & at_last) ? RUN : PAD;
      DROP: state_d = (in_fire & s_axis_tlast) ? RUN : DROP;
      default: state_d = RUN;
    endcase
  end
  // padding zeros and real beats share the counter so the frame-last tag lands on element N*N-1
  always_comb begin
    push = ((state_q == RUN) & in_fire) | ((state_q == PAD) & buf_rdy);
    push_dat = (state_q == PAD) ? '0 : s_axis_tdata[IN_W-1:0];
    cnt_d = push ? (at_last ? '0 : cnt_q + 1'b1) : cnt_q;
    err_short_d = (state_q == RUN) & in_fire & s_axis_tlast & !at_last;
    err_long_d = (state_q == RUN) & in_fire & !s_axis_tlast & at_last;
  end
  axis_skid_buffer #(.W(IN_W + 1)) u_buf (
    .clk      (clk),
    .rstn     (rstn),
    .s_data_i ({at_last, push_dat}),
    .s_vld_i  (push),
    .s_rdy_o  (buf_rdy),
    .m_data_o ({out_tag, m_dat_o}),
    .m_vld_o  (m_vld_o),
    .m_rdy_i  (m_rdy_i)
  );
  assign frame_done_o = m_vld_o & m_rdy_i & out_tag;
  assign err_short_o = err_short_q;
  assign err_long_o = err_long_q;
endmodule

// File: tb/tb_jacobi_input_adapter.sv
// tb_jacobi_input_adapter: directed bench for the adapter with N=2, IN_W=16, AXI_W=32
module tb_jacobi_input_adapter;
  logic clk = 1'b0, rstn = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, m_rdy_i = 1'b1;
  logic s_axis_tready, m_vld_o, frame_done_o, err_short_o, err_long_o;
  logic [15:0] m_dat_o;
  int tests = 0, fails = 0, cyc = 0;
  int n_short = 0, n_long = 0, n_done = 0;
  logic [15:0] oq[$];
  logic dq[$];
  int ocyc[$], icyc[$];

  jacobi_input_adapter #(.AXI_W(32), .IN_W(16), .N(2)) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_dat_o(m_dat_o), .m_vld_o(m_vld_o), .m_rdy_i(m_rdy_i),
    .frame_done_o(frame_done_o), .err_short_o(err_short_o), .err_long_o(err_long_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn) begin
      if (m_vld_o && m_rdy_i) begin
        oq.push_back(m_dat_o);
        dq.push_back(frame_done_o);
        ocyc.push_back(cyc);
      end
      if (s_axis_tvalid && s_axis_tready) icyc.push_back(cyc);
      if (err_short_o) n_short++;
      if (err_long_o) n_long++;
      if (frame_done_o) n_done++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_mon;
    oq.delete(); dq.delete(); ocyc.delete(); icyc.delete();
    n_short = 0; n_long = 0; n_done = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int t = 0;
    s_axis_tdata = d; s_axis_tvalid = 1'b1; s_axis_tlast = l;
    @(negedge clk);
    while (!s_axis_tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_axis_tready) begin
      tests++; fails++;
      $display("FAIL send_timeout: tready got 0 want 1 for beat %h", d);
    end
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    int t = 0;
    while (oq.size() < n && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (oq.size() < n) begin
      tests++; fails++;
      $display("FAIL out_timeout: got %0d elements want %0d", oq.size(), n);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({s_axis_tready, m_vld_o, m_dat_o, frame_done_o, err_short_o, err_long_o} !== 21'd0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b dat=%h done=%b es=%b el=%b want all 0",
               s_axis_tready, m_vld_o, m_dat_o, frame_done_o, err_short_o, err_long_o);
    end
    rstn = 1'b1;
    @(negedge clk);
    tests++;
    if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL reset_rdy_hold: got %b want 0", s_axis_tready); end
    @(negedge clk);
    tests++;
    if (s_axis_tready !== 1'b1) begin fails++; $display("FAIL reset_rdy_rise: got %b want 1", s_axis_tready); end
    @(posedge clk); #1;
  endtask

  task automatic test_frame;
    logic [15:0] exp [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    clear_mon();
    for (int i = 0; i < 4; i++) send(32'(i + 1), i == 3);
    wait_outs(4);
    tests++;
    if (oq.size() != 4) begin fails++; $display("FAIL frame_count: got %0d want 4", oq.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (oq[i] !== exp[i] || dq[i] !== (i == 3)) begin
        fails++;
        $display("FAIL frame_elem[%0d]: got %h/done=%b want %h/done=%b", i, oq[i], dq[i], exp[i], i == 3);
      end
    end
    tests++;
    if (ocyc[0] !== icyc[0] + 1) begin fails++; $display("FAIL frame_latency: got cycle %0d want %0d", ocyc[0], icyc[0] + 1); end
    tests++;
    if (ocyc[3] !== ocyc[0] + 3) begin fails++; $display("FAIL frame_throughput: got cycle %0d want %0d", ocyc[3], ocyc[0] + 3); end
    tests++;
    if (n_short !== 0 || n_long !== 0 || n_done !== 1) begin
      fails++;
      $display("FAIL frame_flags: got short=%0d long=%0d done=%0d want 0 0 1", n_short, n_long, n_done);
    end
  endtask

  task automatic test_backpressure;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] exp [4] = '{16'h0005, 16'h0006, 16'h0007, 16'h0008};
    logic [15:0] pd;
    logic ps;
    int nstall;
    ps = 1'b0; pd = '0; nstall = 0;
    clear_mon();
    fork
      for (int i = 0; i < 4; i++) send(32'(i + 5), i == 3);
      begin
        for (int i = 0; i < 16; i++) begin
          m_rdy_i = pat[i % 4];
          @(posedge clk); #1;
        end
        m_rdy_i = 1'b1;
      end
      repeat (24) begin
        @(negedge clk);
        if (ps) begin
          tests++;
          if (m_vld_o !== 1'b1 || m_dat_o !== pd) begin
            fails++;
            $display("FAIL bp_hold: got vld=%b dat=%h want vld=1 dat=%h", m_vld_o, m_dat_o, pd);
          end
        end
        ps = m_vld_o & !m_rdy_i;
        pd = m_dat_o;
        if (s_axis_tvalid && !s_axis_tready) nstall++;
      end
    join
    wait_outs(4);
    tests++;
    if (oq.size() != 4) begin fails++; $display("FAIL bp_count: got %0d want 4", oq.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (oq[i] !== exp[i] || dq[i] !== (i == 3)) begin
        fails++;
        $display("FAIL bp_elem[%0d]: got %h/done=%b want %h/done=%b", i, oq[i], dq[i], exp[i], i == 3);
      end
    end
    tests++;
    if (nstall == 0) begin fails++; $display("FAIL bp_tready: got %0d stalled beats want >0", nstall); end
  endtask

  task automatic test_short;
    logic [15:0] exp [4] = '{16'h0011, 16'h0022, 16'h0000, 16'h0000};
    clear_mon();
    send(32'h11, 1'b0);
    send(32'h22, 1'b1);
    wait_outs(4);
    tests++;
    if (oq.size() != 4) begin fails++; $display("FAIL short_count: got %0d want 4", oq.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (oq[i] !== exp[i] || dq[i] !== (i == 3)) begin
        fails++;
        $display("FAIL short_elem[%0d]: got %h/done=%b want %h/done=%b", i, oq[i], dq[i], exp[i], i == 3);
      end
    end
    tests++;
    if (n_short !== 1 || n_long !== 0) begin fails++; $display("FAIL short_err: got short=%0d long=%0d want 1 0", n_short, n_long); end
    clear_mon();
    for (int i = 0; i < 4; i++) send(32'(8'h31 + i), i == 3);
    wait_outs(4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (oq[i] !== 16'(8'h31 + i) || dq[i] !== (i == 3)) begin
        fails++;
        $display("FAIL short_next[%0d]: got %h/done=%b want %h/done=%b", i, oq[i], dq[i], 16'(8'h31 + i), i == 3);
      end
    end
    tests++;
    if (oq.size() != 4 || n_short !== 0 || n_long !== 0) begin
      fails++;
      $display("FAIL short_next_flags: got n=%0d short=%0d long=%0d want 4 0 0", oq.size(), n_short, n_long);
    end
  endtask

  task automatic test_long;
    clear_mon();
    for (int i = 0; i < 6; i++) send(32'(8'h41 + i), i == 5);
    wait_outs(4);
    tests++;
    if (oq.size() != 4) begin fails++; $display("FAIL long_count: got %0d want 4", oq.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (oq[i] !== 16'(8'h41 + i) || dq[i] !== (i == 3)) begin
        fails++;
        $display("FAIL long_elem[%0d]: got %h/done=%b want %h/done=%b", i, oq[i], dq[i], 16'(8'h41 + i), i == 3);
      end
    end
    tests++;
    if (n_long !== 1 || n_short !== 0) begin fails++; $display("FAIL long_err: got long=%0d short=%0d want 1 0", n_long, n_short); end
    clear_mon();
    for (int i = 0; i < 4; i++) send(32'(8'h51 + i), i == 3);
    wait_outs(4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (oq[i] !== 16'(8'h51 + i) || dq[i] !== (i == 3)) begin
        fails++;
        $display("FAIL long_next[%0d]: got %h/done=%b want %h/done=%b", i, oq[i], dq[i], 16'(8'h51 + i), i == 3);
      end
    end
    tests++;
    if (oq.size() != 4 || n_short !== 0 || n_long !== 0) begin
      fails++;
      $display("FAIL long_next_flags: got n=%0d short=%0d long=%0d want 4 0 0", oq.size(), n_short, n_long);
    end
  endtask

  task automatic test_width;
    logic [31:0] beats [4] = '{32'hDEAD_BEEF, 32'hFFFF_0002, 32'h1234_0003, 32'hABCD_0004};
    logic [15:0] exp [4] = '{16'hBEEF, 16'h0002, 16'h0003, 16'h0004};
    clear_mon();
    for (int i = 0; i < 4; i++) send(beats[i], i == 3);
    wait_outs(4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (oq[i] !== exp[i]) begin fails++; $display("FAIL width_elem[%0d]: got %h want %h", i, oq[i], exp[i]); end
    end
  endtask

  task automatic test_async_reset;
    clear_mon();
    m_rdy_i = 1'b0;
    send(32'h71, 1'b0);
    send(32'h72, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    tests++;
    if ({s_axis_tready, m_vld_o, m_dat_o, frame_done_o, err_short_o, err_long_o} !== 21'd0) begin
      fails++;
      $display("FAIL areset_outputs: got rdy=%b vld=%b dat=%h done=%b es=%b el=%b want all 0",
               s_axis_tready, m_vld_o, m_dat_o, frame_done_o, err_short_o, err_long_o);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    m_rdy_i = 1'b1;
    clear_mon();
    for (int i = 0; i < 4; i++) send(32'(8'h61 + i), i == 3);
    wait_outs(4);
    tests++;
    if (oq.size() != 4) begin fails++; $display("FAIL areset_count: got %0d want 4", oq.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (oq[i] !== 16'(8'h61 + i) || dq[i] !== (i == 3)) begin
        fails++;
        $display("FAIL areset_elem[%0d]: got %h/done=%b want %h/done=%b", i, oq[i], dq[i], 16'(8'h61 + i), i == 3);
      end
    end
    tests++;
    if (n_short !== 0 || n_long !== 0 || n_done !== 1) begin
      fails++;
      $display("FAIL areset_flags: got short=%0d long=%0d done=%0d want 0 0 1", n_short, n_long, n_done);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_short();
    test_long();
    test_width();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
